// File: rtl/pipe_stall_ctrl_pkg.sv
// rtl/pipe_stall_ctrl_pkg.sv - shared state encoding, widths and latency helper for pipe_stall_ctrl
package pipe_stall_ctrl_pkg;

  localparam int REG_W   = 5;
  localparam int CNT_W   = 6;
  localparam int LAT_MIN = 2;
  localparam int LAT_MAX = 63;

  localparam logic [31:0] STALL_MAX = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_MDU_BUSY = 2'd1,
    ST_MDU_DONE = 2'd2,
    ST_BAD      = 2'd3
  } state_t;

  // The start cycle is the first busy cycle, so the counter holds the busy cycles left after it.
  function automatic logic [CNT_W-1:0] busy_count(input int lat);
    int l;
    l = (lat < LAT_MIN) ? LAT_MIN : ((lat > LAT_MAX) ? LAT_MAX : lat);
    return CNT_W'(l - 1);
  endfunction

endpackage

// File: rtl/pipe_stall_ctrl_hazard_detect.sv
// rtl/pipe_stall_ctrl_hazard_detect.sv - combinational load-use hazard compare between ID sources and EX load
module hazard_detect
  import pipe_stall_ctrl_pkg::*;
(
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_uses_rs,
  input  logic             id_uses_rt,
  input  logic             ex_is_load,
  input  logic [REG_W-1:0] ex_rd,
  output logic             hazard
);

  logic rs_hit;
  logic rt_hit;

  assign rs_hit = id_uses_rs && (id_rs == ex_rd);
  assign rt_hit = id_uses_rt && (id_rt == ex_rd);
  // r0 is hardwired zero, so a load into it never creates a dependency.
  assign hazard = ex_is_load && (ex_rd != '0) && (rs_hit || rt_hit);

endmodule

// File: rtl/pipe_stall_ctrl.sv
// rtl/pipe_stall_ctrl.sv - pipeline stall/flush control with load-use, branch and multi-cycle MDU sequencing
module pipe_stall_ctrl
  import pipe_stall_ctrl_pkg::*;
#(
  parameter int MUL_LAT = 4,
  parameter int DIV_LAT = 32
) (
  input  logic             in_clk,
  input  logic             in_rst,
  input  logic [REG_W-1:0] in_id_rs,
  input  logic [REG_W-1:0] in_id_rt,
  input  logic             in_id_uses_rs,
  input  logic             in_id_uses_rt,
  input  logic             in_ex_is_load,
  input  logic [REG_W-1:0] in_ex_rd,
  input  logic             in_ex_branch_taken,
  input  logic             in_ex_mdu_start,
  input  logic             in_ex_is_div,
  output logic             out_pc_wena,
  output logic             out_ifid_wena,
  output logic             out_idex_wena,
  output logic             out_exmem_wena,
  output logic             out_memwb_wena,
  output logic             out_ifid_flush,
  output logic             out_idex_flush,
  output logic             out_exmem_flush,
  output logic             out_mdu_busy,
  output logic             out_mdu_done,
  output logic [1:0]       out_state,
  output logic [31:0]      out_stall_cnt
);

  localparam logic [CNT_W-1:0] MUL_CNT = busy_count(MUL_LAT);
  localparam logic [CNT_W-1:0] DIV_CNT = busy_count(DIV_LAT);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      stall_q;
  logic             hazard;

  hazard_detect u_hazard (
    .id_rs      (in_id_rs),
    .id_rt      (in_id_rt),
    .id_uses_rs (in_id_uses_rs),
    .id_uses_rt (in_id_uses_rt),
    .ex_is_load (in_ex_is_load),
    .ex_rd      (in_ex_rd),
    .hazard     (hazard)
  );

  always_comb begin
    state_d         = state_q;
    cnt_d           = cnt_q;
    out_pc_wena     = 1'b1;
    out_ifid_wena   = 1'b1;
    out_idex_wena   = 1'b1;
    out_exmem_wena  = 1'b1;
    out_memwb_wena  = 1'b1;
    out_ifid_flush  = 1'b0;
    out_idex_flush  = 1'b0;
    out_exmem_flush = 1'b0;
    out_mdu_busy    = 1'b0;
    out_mdu_done    = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (in_ex_mdu_start) begin
          state_d         = ST_MDU_BUSY;
          cnt_d           = in_ex_is_div ? DIV_CNT : MUL_CNT;
          out_pc_wena     = 1'b0;
          out_ifid_wena   = 1'b0;
          out_idex_wena   = 1'b0;
          out_exmem_flush = 1'b1;
          out_mdu_busy    = 1'b1;
        end else if (in_ex_branch_taken) begin
          out_ifid_flush = 1'b1;
          out_idex_flush = 1'b1;
        end else if (hazard) begin
          out_pc_wena    = 1'b0;
          out_ifid_wena  = 1'b0;
          out_idex_flush = 1'b1;
        end
      end
      ST_MDU_BUSY: begin
        out_pc_wena     = 1'b0;
        out_ifid_wena   = 1'b0;
        out_idex_wena   = 1'b0;
        out_exmem_flush = 1'b1;
        out_mdu_busy    = 1'b1;
        cnt_d           = cnt_q - 1'b1;
        if (cnt_q <= CNT_W'(1)) begin
          state_d = ST_MDU_DONE;
          cnt_d   = '0;
        end
      end
      ST_MDU_DONE: begin
        out_mdu_done = 1'b1;
        state_d      = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Reset holds the pipeline in its free-running configuration.
    if (in_rst) begin
      out_pc_wena     = 1'b1;
      out_ifid_wena   = 1'b1;
      out_idex_wena   = 1'b1;
      out_exmem_wena  = 1'b1;
      out_memwb_wena  = 1'b1;
      out_ifid_flush  = 1'b0;
      out_idex_flush  = 1'b0;
      out_exmem_flush = 1'b0;
      out_mdu_busy    = 1'b0;
      out_mdu_done    = 1'b0;
    end
  end

  always_ff @(posedge in_clk) begin
    if (in_rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      stall_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (!out_pc_wena && (stall_q != STALL_MAX)) begin
        stall_q <= stall_q + 32'd1;
      end
    end
  end

  assign out_state     = state_q;
  assign out_stall_cnt = stall_q;

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// tb/tb_pipe_stall_ctrl.sv - self-checking bench for pipe_stall_ctrl with a cycle-schedule reference model
module tb_pipe_stall_ctrl;

  localparam int MUL_LAT = 4;
  localparam int DIV_LAT = 32;

  logic        in_clk = 1'b0;
  logic        in_rst;
  logic [4:0]  in_id_rs, in_id_rt, in_ex_rd;
  logic        in_id_uses_rs, in_id_uses_rt;
  logic        in_ex_is_load, in_ex_branch_taken, in_ex_mdu_start, in_ex_is_div;
  logic        out_pc_wena, out_ifid_wena, out_idex_wena, out_exmem_wena, out_memwb_wena;
  logic        out_ifid_flush, out_idex_flush, out_exmem_flush;
  logic        out_mdu_busy, out_mdu_done;
  logic [1:0]  out_state;
  logic [31:0] out_stall_cnt;

  logic [4:0]  wena_vec;
  logic [2:0]  flush_vec;

  int          checks = 0;
  int          failures = 0;
  bit          chk_en = 1'b0;
  bit          m_force_bad = 1'b0;
  int          m_cyc = 0;
  int          m_done_cyc = -1;
  logic [31:0] m_stall = 32'd0;

  pipe_stall_ctrl #(.MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT)) dut (
    .in_clk             (in_clk),
    .in_rst             (in_rst),
    .in_id_rs           (in_id_rs),
    .in_id_rt           (in_id_rt),
    .in_id_uses_rs      (in_id_uses_rs),
    .in_id_uses_rt      (in_id_uses_rt),
    .in_ex_is_load      (in_ex_is_load),
    .in_ex_rd           (in_ex_rd),
    .in_ex_branch_taken (in_ex_branch_taken),
    .in_ex_mdu_start    (in_ex_mdu_start),
    .in_ex_is_div       (in_ex_is_div),
    .out_pc_wena        (out_pc_wena),
    .out_ifid_wena      (out_ifid_wena),
    .out_idex_wena      (out_idex_wena),
    .out_exmem_wena     (out_exmem_wena),
    .out_memwb_wena     (out_memwb_wena),
    .out_ifid_flush     (out_ifid_flush),
    .out_idex_flush     (out_idex_flush),
    .out_exmem_flush    (out_exmem_flush),
    .out_mdu_busy       (out_mdu_busy),
    .out_mdu_done       (out_mdu_done),
    .out_state          (out_state),
    .out_stall_cnt      (out_stall_cnt)
  );

  always #5 in_clk = ~in_clk;

  assign wena_vec  = {out_pc_wena, out_ifid_wena, out_idex_wena, out_exmem_wena, out_memwb_wena};
  assign flush_vec = {out_ifid_flush, out_idex_flush, out_exmem_flush};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge in_clk);
    #1;
  endtask

  task automatic idle_inputs();
    in_id_rs = 5'd0; in_id_rt = 5'd0; in_id_uses_rs = 1'b0; in_id_uses_rt = 1'b0;
    in_ex_is_load = 1'b0; in_ex_rd = 5'd0; in_ex_branch_taken = 1'b0;
    in_ex_mdu_start = 1'b0; in_ex_is_div = 1'b0;
  endtask

  task automatic rand_inputs(input bit allow_start);
    in_id_rs           = 5'($urandom_range(0, 7));
    in_id_rt           = 5'($urandom_range(0, 7));
    in_ex_rd           = 5'($urandom_range(0, 7));
    in_id_uses_rs      = ($urandom_range(0, 1) == 1);
    in_id_uses_rt      = ($urandom_range(0, 1) == 1);
    in_ex_is_load      = ($urandom_range(0, 2) == 0);
    in_ex_branch_taken = ($urandom_range(0, 7) == 0);
    in_ex_is_div       = ($urandom_range(0, 1) == 1);
    in_ex_mdu_start    = allow_start && !in_ex_is_load && !in_ex_branch_taken &&
                         ($urandom_range(0, 15) == 0);
  endtask

  // Reference model: MDU occupancy is a schedule of absolute cycle numbers, not a counter.
  always @(negedge in_clk) begin
    if (chk_en) begin
      int         phase;
      bit         haz;
      logic [4:0] ew;
      logic [2:0] ef;
      bit         eb, ed;

      if (m_force_bad)                                phase = 3;
      else if (m_done_cyc >= 0 && m_cyc < m_done_cyc) phase = 1;
      else if (m_cyc == m_done_cyc)                   phase = 2;
      else                                            phase = 0;

      haz = in_ex_is_load && (in_ex_rd != 5'd0) &&
            ((in_id_uses_rs && in_id_rs == in_ex_rd) || (in_id_uses_rt && in_id_rt == in_ex_rd));

      ew = 5'b11111; ef = 3'b000; eb = 1'b0; ed = 1'b0;
      if (!in_rst) begin
        if (phase == 0) begin
          if (in_ex_mdu_start)         begin ew = 5'b00011; ef = 3'b001; eb = 1'b1; end
          else if (in_ex_branch_taken) begin ef = 3'b110; end
          else if (haz)                begin ew = 5'b00111; ef = 3'b010; end
        end else if (phase == 1) begin
          ew = 5'b00011; ef = 3'b001; eb = 1'b1;
        end else if (phase == 2) begin
          ed = 1'b1;
        end
      end

      chk("cyc_wena", {27'd0, wena_vec}, {27'd0, ew});
      chk("cyc_flush", {29'd0, flush_vec}, {29'd0, ef});
      chk("cyc_busy", {31'd0, out_mdu_busy}, {31'd0, eb});
      chk("cyc_done", {31'd0, out_mdu_done}, {31'd0, ed});
      chk("cyc_state", {30'd0, out_state}, 32'(phase));
      chk("cyc_stall", out_stall_cnt, m_stall);

      if (in_rst) begin
        m_stall    = 32'd0;
        m_done_cyc = -1;
      end else begin
        if (!ew[4] && m_stall != 32'hFFFF_FFFF) m_stall = m_stall + 32'd1;
        if (phase == 0 && in_ex_mdu_start)
          m_done_cyc = m_cyc + (in_ex_is_div ? DIV_LAT : MUL_LAT);
      end
      m_force_bad = 1'b0;
      m_cyc++;
    end
  end

  initial begin
    int busy_n, done_n, done_idx, leak;
    logic [31:0] stall_at_done;

    idle_inputs();
    in_rst = 1'b1;
    repeat (2) @(posedge in_clk);
    #1 chk_en = 1'b1;
    #2;
    chk("rst_state", {30'd0, out_state}, 32'd0);
    chk("rst_stall", out_stall_cnt, 32'd0);
    chk("rst_wena", {27'd0, wena_vec}, 32'h1f);
    chk("rst_flush", {29'd0, flush_vec}, 32'd0);

    step(); in_rst = 1'b0;
    in_ex_is_load = 1'b1; in_ex_rd = 5'd5; in_id_rs = 5'd5; in_id_uses_rs = 1'b1;
    #2;
    chk("lu_wena", {27'd0, wena_vec}, 32'h07);
    chk("lu_flush", {29'd0, flush_vec}, 32'h2);
    chk("lu_stall_pre", out_stall_cnt, 32'd0);
    step(); idle_inputs(); #2;
    chk("lu_stall_post", out_stall_cnt, 32'd1);
    chk("lu_release", {31'd0, out_pc_wena}, 32'd1);

    step(); in_ex_is_load = 1'b1; in_ex_rd = 5'd0; in_id_rs = 5'd0; in_id_uses_rs = 1'b1; #2;
    chk("r0_wena", {27'd0, wena_vec}, 32'h1f);
    step(); idle_inputs(); #2;
    chk("r0_stall", out_stall_cnt, 32'd1);

    step(); in_ex_is_load = 1'b1; in_ex_rd = 5'd5; in_id_rs = 5'd5; in_id_uses_rs = 1'b1;
    in_ex_branch_taken = 1'b1; #2;
    chk("br_pc", {31'd0, out_pc_wena}, 32'd1);
    chk("br_flush", {29'd0, flush_vec}, 32'h6);
    step(); idle_inputs(); #2;
    chk("br_stall", out_stall_cnt, 32'd1);

    step(); in_rst = 1'b1;
    step(); in_rst = 1'b0; in_ex_mdu_start = 1'b1; in_ex_is_div = 1'b1; #2;
    chk("div_stall_pre", out_stall_cnt, 32'd0);
    busy_n = int'(out_mdu_busy); done_n = 0; done_idx = -1; leak = 0; stall_at_done = '0;
    for (int i = 0; i < 40; i++) begin
      step(); rand_inputs(1'b0); #2;
      busy_n += int'(out_mdu_busy);
      if (out_mdu_busy && (out_ifid_flush || out_idex_flush)) leak++;
      if (out_mdu_done) begin
        done_n++;
        done_idx = i;
        stall_at_done = out_stall_cnt;
      end
    end
    chk("div_busy_cycles", 32'(busy_n), 32'd32);
    chk("div_done_pulses", 32'(done_n), 32'd1);
    chk("div_done_at", 32'(done_idx), 32'd31);
    chk("div_stall", stall_at_done, 32'd32);
    chk("div_ignore_br", 32'(leak), 32'd0);
    chk("div_end_state", {30'd0, out_state}, 32'd0);

    step(); idle_inputs(); in_ex_mdu_start = 1'b1; in_ex_is_div = 1'b0;
    step(); idle_inputs();
    step(); in_rst = 1'b1; #2;
    chk("mul_rst_wena", {27'd0, wena_vec}, 32'h1f);
    chk("mul_rst_flush", {29'd0, flush_vec}, 32'd0);
    step(); in_rst = 1'b0; #2;
    chk("mul_rst_state", {30'd0, out_state}, 32'd0);
    chk("mul_rst_busy", {31'd0, out_mdu_busy}, 32'd0);
    chk("mul_rst_stall", out_stall_cnt, 32'd0);

    step();
    force dut.state_q = pipe_stall_ctrl_pkg::ST_BAD;
    m_force_bad = 1'b1;
    #2;
    chk("bad_state", {30'd0, out_state}, 32'd3);
    chk("bad_wena", {27'd0, wena_vec}, 32'h1f);
    #4;
    release dut.state_q;
    step(); #2;
    chk("bad_recover", {30'd0, out_state}, 32'd0);
    chk("bad_defaults", {27'd0, wena_vec}, 32'h1f);

    for (int i = 0; i < 3000; i++) begin
      step();
      in_rst = ($urandom_range(0, 99) == 0);
      rand_inputs(1'b1);
    end
    step();
    chk_en = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
